// File: rtl/generic_1bit_tdm_demux.sv
// generic_1bit_tdm_demux: receive side of a 1-bit TDM link. Tracks the slot
// position from a frame-sync marker, collects one bit per slot in a shadow
// register and publishes each complete frame as a registered word with a
// one-cycle valid pulse. Framing violations raise a one-cycle error pulse.
module generic_1bit_tdm_demux #(
  parameter int unsigned OUTs = 5,
  parameter int unsigned SW   = $clog2(OUTs)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            sync,
  input  logic            din,
  output logic [OUTs-1:0] y,
  output logic [SW-1:0]   s,
  output logic            frame_valid,
  output logic            sync_err,
  output logic            locked
);

  typedef enum logic {
    StHunt,
    StLock
  } state_e;

  // Index of the final slot; cnt never counts past it.
  localparam logic [SW-1:0] LastSlot = SW'(OUTs - 1);
  localparam logic [SW-1:0] Slot1    = SW'(1);

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [OUTs-1:0] sh_q, sh_d;
  logic [OUTs-1:0] y_q, y_d;
  logic            frame_valid_q, frame_valid_d;
  logic            sync_err_q, sync_err_d;

  // Next-state logic: framing FSM, slot counter and bit steering.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    y_d           = y_q;
    // Pulses drop back to 0 unless re-asserted this cycle.
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        StHunt: begin
          // Non-sync bits are silently ignored while hunting.
          if (sync) begin
            sh_d[0] = din;
            cnt_d   = Slot1;
            state_d = StLock;
          end
        end

        StLock: begin
          if (sync) begin
            // Sync anywhere but slot 0 aborts the partial frame; the bit
            // still starts a fresh frame.
            if (cnt_q != '0) begin
              sync_err_d = 1'b1;
            end
            sh_d[0] = din;
            cnt_d   = Slot1;
          end else if (cnt_q == '0) begin
            // Expected a frame start but none came: lose lock, drop bit.
            sync_err_d = 1'b1;
            state_d    = StHunt;
          end else if (cnt_q == LastSlot) begin
            y_d           = {din, sh_q[OUTs-2:0]};
            frame_valid_d = 1'b1;
            cnt_d         = '0;
          end else begin
            sh_d[cnt_q] = din;
            cnt_d       = cnt_q + Slot1;
          end
        end

        default: begin
          state_d = StHunt;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StHunt;
      cnt_q         <= '0;
      sh_q          <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign y           = y_q;
  assign s           = cnt_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == StLock);

endmodule

// File: tb/tb_generic_1bit_tdm_demux.sv
// Self-checking bench for generic_1bit_tdm_demux (OUTs=5): directed scenarios
// followed by randomized traffic compared against a queue-based frame model.
module tb_generic_1bit_tdm_demux;

  localparam int unsigned OUTS = 5;
  localparam int unsigned SWB  = $clog2(OUTS);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic            sync = 1'b0;
  logic            din = 1'b0;
  logic [OUTS-1:0] y;
  logic [SWB-1:0]  s;
  logic            frame_valid;
  logic            sync_err;
  logic            locked;

  int total = 0;
  int bad   = 0;

  // Reference model: the bits of the frame in progress, in arrival order.
  bit              mq[$];
  bit              m_lock = 1'b0;
  logic [OUTS-1:0] m_y    = '0;
  logic            m_fv   = 1'b0;
  logic            m_se   = 1'b0;

  generic_1bit_tdm_demux #(.OUTs(OUTS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .sync        (sync),
    .din         (din),
    .y           (y),
    .s           (s),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic e, input logic sy, input logic d);
    logic [OUTS-1:0] w;
    m_fv = 1'b0;
    m_se = 1'b0;
    if (!r) begin
      mq.delete();
      m_lock = 1'b0;
      m_y    = '0;
    end else if (e) begin
      if (!m_lock) begin
        if (sy) begin
          mq.delete();
          mq.push_back(d);
          m_lock = 1'b1;
        end
      end else if (sy) begin
        if (mq.size() != 0) m_se = 1'b1;
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() == 0) begin
        m_se   = 1'b1;
        m_lock = 1'b0;
      end else begin
        mq.push_back(d);
        if (mq.size() == OUTS) begin
          w = '0;
          for (int i = 0; i < OUTS; i++) w[i] = mq[i];
          m_y  = w;
          m_fv = 1'b1;
          mq.delete();
        end
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic cyc(input logic r, input logic e, input logic sy, input logic d);
    reset_n = r;
    en      = e;
    sync    = sy;
    din     = d;
    @(posedge clk);
    model_step(r, e, sy, d);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      total++;
      if (y !== '0 || s !== '0 || locked !== 1'b0 || frame_valid !== 1'b0 ||
          sync_err !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc=%0d got y=%b s=%0d lk=%b fv=%b se=%b exp all zero",
                 i, y, s, locked, frame_valid, sync_err);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_nominal;
    logic [4:0] bits = 5'b01101;
    int exp_s;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, (i == 0), bits[i]);
      exp_s = (i + 1) % 5;
      total++;
      if (s !== SWB'(exp_s) || locked !== 1'b1) begin
        bad++;
        $display("FAIL nominal_s slot=%0d got s=%0d lk=%b exp s=%0d lk=1", i, s, locked, exp_s);
      end
      total++;
      if (frame_valid !== (i == 4)) begin
        bad++;
        $display("FAIL nominal_fv slot=%0d got=%b exp=%b", i, frame_valid, (i == 4));
      end
    end
    total++;
    if (y !== 5'b01101) begin
      bad++;
      $display("FAIL nominal_y got=%b exp=%b", y, 5'b01101);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);  // sync missing -> hunt, no further pulse of fv
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL nominal_fv_width got=%b exp=0", frame_valid);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [4:0] frames [3] = '{5'b10011, 5'b00001, 5'b11010};
    int fv_cnt = 0;
    int se_cnt = 0;
    // Two frames with en toggling 1,0.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 5; i++) begin
        cyc(1'b1, 1'b1, (i == 0), frames[f][i]);
        fv_cnt += int'(frame_valid);
        se_cnt += int'(sync_err);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);  // gap: inputs must be ignored
        fv_cnt += int'(frame_valid);
        se_cnt += int'(sync_err);
      end
      total++;
      if (y !== frames[f]) begin
        bad++;
        $display("FAIL b2b_gap_y frame=%0d got=%b exp=%b", f, y, frames[f]);
      end
    end
    total++;
    if (fv_cnt != 2 || se_cnt != 0) begin
      bad++;
      $display("FAIL b2b_gap_pulses got fv=%0d se=%0d exp fv=2 se=0", fv_cnt, se_cnt);
    end
    // Three frames with en held high, no bubble.
    fv_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 5; i++) begin
        cyc(1'b1, 1'b1, (i == 0), frames[f][i]);
        fv_cnt += int'(frame_valid);
        total++;
        if (frame_valid !== (i == 4) || sync_err !== 1'b0) begin
          bad++;
          $display("FAIL b2b_cont frame=%0d slot=%0d got fv=%b se=%b exp fv=%b se=0",
                   f, i, frame_valid, sync_err, (i == 4));
        end
      end
      total++;
      if (y !== frames[f]) begin
        bad++;
        $display("FAIL b2b_cont_y frame=%0d got=%b exp=%b", f, y, frames[f]);
      end
    end
  endtask

  task automatic test_early_sync;
    logic [4:0] y_before = y;
    int fv_cnt = 0;
    int se_cnt = 0;
    logic [7:0] dbits = 8'b1000_1111;  // bit k = din of step k
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, (k == 0 || k == 3), dbits[k]);
      fv_cnt += int'(frame_valid);
      se_cnt += int'(sync_err);
      if (k == 3) begin
        total++;
        if (sync_err !== 1'b1 || y !== y_before || s !== SWB'(1)) begin
          bad++;
          $display("FAIL early_sync_edge got se=%b y=%b s=%0d exp se=1 y=%b s=1",
                   sync_err, y, s, y_before);
        end
      end
    end
    total++;
    if (se_cnt != 1 || fv_cnt != 1) begin
      bad++;
      $display("FAIL early_sync_pulses got se=%0d fv=%0d exp se=1 fv=1", se_cnt, fv_cnt);
    end
    total++;
    if (y !== 5'b10001) begin
      bad++;
      $display("FAIL early_sync_y got=%b exp=%b", y, 5'b10001);
    end
  endtask

  task automatic test_missing_sync;
    logic [4:0] good = 5'b10110;
    logic [4:0] relock = 5'b01010;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, (i == 0), good[i]);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || s !== '0) begin
      bad++;
      $display("FAIL missing_sync got se=%b lk=%b s=%0d exp se=1 lk=0 s=0", sync_err, locked, s);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, i[0]);
      total++;
      if (y !== good || locked !== 1'b0 || sync_err !== 1'b0 || frame_valid !== 1'b0) begin
        bad++;
        $display("FAIL hunt_ignore i=%0d got y=%b lk=%b se=%b fv=%b exp y=%b lk=0 se=0 fv=0",
                 i, y, locked, sync_err, frame_valid, good);
      end
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, (i == 0), relock[i]);
    total++;
    if (y !== relock || frame_valid !== 1'b1 || locked !== 1'b1) begin
      bad++;
      $display("FAIL relock got y=%b fv=%b lk=%b exp y=%b fv=1 lk=1", y, frame_valid, locked,
               relock);
    end
  endtask

  task automatic test_mid_reset;
    logic [4:0] nxt = 5'b11100;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, (i == 0), 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (y !== '0 || s !== '0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got y=%b s=%0d lk=%b exp y=0 s=0 lk=0", y, s, locked);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, (i == 0), nxt[i]);
    total++;
    if (y !== nxt || frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_frame got y=%b fv=%b exp y=%b fv=1", y, frame_valid, nxt);
    end
  endtask

  task automatic test_random;
    int tx_slot = 0;
    int errs = 0;
    logic r, e, sy, d;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) != 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom);
      sy = (tx_slot == 0);
      if ($urandom_range(0, 19) == 0) sy = ~sy;
      if (!r) tx_slot = 0;
      else if (e) tx_slot = (sy ? 1 : tx_slot + 1) % OUTS;
      cyc(r, e, sy, d);
      total++;
      if (y !== m_y || s !== SWB'(mq.size()) || frame_valid !== m_fv ||
          sync_err !== m_se || locked !== m_lock) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random n=%0d got y=%b s=%0d fv=%b se=%b lk=%b exp y=%b s=%0d fv=%b se=%b lk=%b",
                   n, y, s, frame_valid, sync_err, locked, m_y, mq.size(), m_fv, m_se, m_lock);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
